// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB register-file slave:
//   - apb_state_e : protocol FSM states (IDLE / SETUP / ACCESS)
//   - REG_CNT     : index of the counter/status register
//   - REG_ID      : index of the read-only ID register
//   - WIN_BITS    : log2 of the 64-byte address window
//   - apb_cap_t   : setup-phase capture of address, direction and data
//   - sat_inc16   : saturating 16-bit increment used by both counters
// ---------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [3:0]  REG_CNT     = 4'd14;
  localparam logic [3:0]  REG_ID      = 4'd15;
  localparam int unsigned NUM_RW_REGS = 14;
  localparam int unsigned WIN_BITS    = 6;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } apb_cap_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile_if
// APB bus between the AHB-to-APB bridge (master) and one register-file slave.
//   Pwrite  : 1 = write, 0 = read
//   Psel    : one-hot slave select, one bit per slave slot
//   Penable : access-phase strobe
//   Paddr   : byte address
//   Pwdata  : write data
//   Pr_data : read data returned to the bridge
//   Perr    : one-cycle protocol/decode error pulse
// ---------------------------------------------------------------------------
interface apb_slave_regfile_if;

  logic        Pwrite;
  logic [2:0]  Psel;
  logic        Penable;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Pr_data;
  logic        Perr;

  modport master (
    output Pwrite, Psel, Penable, Paddr, Pwdata,
    input  Pr_data, Perr
  );

  modport slave (
    input  Pwrite, Psel, Penable, Paddr, Pwdata,
    output Pr_data, Perr
  );

endinterface

// File: rtl/apb_protocol_fsm.sv
// ---------------------------------------------------------------------------
// apb_protocol_fsm
// Tracks the APB setup/access sequence seen by one slave and flags protocol
// violations. The state is registered, so it trails the bus by one cycle:
// state SETUP means the previous cycle was a setup phase and the bus should
// now be in its access phase.
//   Hclk, Hreset : clock, synchronous active-high reset
//   sel          : this slave's Psel bit
//   Penable      : APB access strobe
//   stable       : address/direction/data still equal to the setup capture
//   state        : current protocol state
//   setup_done   : a setup phase is being sampled this edge (take a capture)
//   access_ok    : a clean access phase ends this edge (commit / load read)
//   err          : a protocol error is being sampled this edge
// ---------------------------------------------------------------------------
module apb_protocol_fsm
  import apb_pkg::*;
(
  input  logic       Hclk,
  input  logic       Hreset,
  input  logic       sel,
  input  logic       Penable,
  input  logic       stable,
  output apb_state_e state,
  output logic       setup_done,
  output logic       access_ok,
  output logic       err
);

  apb_state_e next_state;

  // The strobes are decided from the current state and the bus inputs so the
  // top can act on the same edge that ends each bus phase.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and no latch is inferred.
    next_state = state;
    setup_done = 1'b0;
    access_ok  = 1'b0;
    err        = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel && !Penable) begin
          next_state = SETUP;
          setup_done = 1'b1;
        end else if (sel && Penable) begin
          err = 1'b1;              // access phase without a setup phase
        end
      end
      SETUP: begin
        if (!sel) begin
          err        = 1'b1;       // transfer abandoned after setup
          next_state = IDLE;
        end else if (!Penable) begin
          setup_done = 1'b1;       // setup repeated: re-take the capture
        end else begin
          next_state = ACCESS;
          access_ok  = stable;
          err        = !stable;
        end
      end
      ACCESS: begin
        if (!sel) begin
          next_state = IDLE;
        end else if (!Penable) begin
          next_state = SETUP;      // back-to-back transfer
          setup_done = 1'b1;
        end else begin
          err        = 1'b1;       // no wait states, so Penable may not persist
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block ordering.
    if (Hreset) state <= IDLE;
    else        state <= next_state;
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
// APB register-file slave: 14 read/write words, a counter/status word at
// index 14 ({err_cnt, wr_cnt}, cleared by any write) and a read-only ID word
// at index 15, in a 64-byte window at BASE_ADDR.
//   SLOT      : which Psel bit selects this slave (0..2)
//   BASE_ADDR : window base address (64-byte aligned)
//   ID_VALUE  : constant returned by register 15
//   Hclk      : clock
//   Hreset    : synchronous active-high reset
//   bus       : APB slave port (Psel/Penable/Pwrite/Paddr/Pwdata in,
//               Pr_data/Perr out)
// ---------------------------------------------------------------------------
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned SLOT      = 0,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] ID_VALUE  = 32'hA5B0_0001
) (
  input logic                Hclk,
  input logic                Hreset,
  apb_slave_regfile_if.slave bus
);

  localparam logic [1:0] SLOT_IDX = 2'(SLOT);

  apb_state_e  state;
  logic        sel;
  logic        stable;
  logic        setup_done;
  logic        access_ok;
  logic        fsm_err;
  apb_cap_t    cap_q;
  logic [31:0] regs [NUM_RW_REGS];
  logic [15:0] wr_cnt;
  logic [15:0] err_cnt;
  logic [31:0] pr_data_q;
  logic        perr_q;
  logic [3:0]  idx;
  logic        in_window;
  logic        wr_hit;
  logic        cnt_clr;
  logic        rd_load;
  logic        err_event;
  logic [31:0] rd_data;
  logic        unused_psel;

  // Only our own select bit matters; the others belong to sibling slaves.
  assign sel         = bus.Psel[SLOT_IDX];
  assign unused_psel = ^bus.Psel;

  // Any change between the sampled setup phase and the access phase is a
  // protocol violation.
  assign stable = (bus.Paddr  == cap_q.addr)  &&
                  (bus.Pwrite == cap_q.write) &&
                  (bus.Pwdata == cap_q.wdata);

  apb_protocol_fsm u_fsm (
    .Hclk       (Hclk),
    .Hreset     (Hreset),
    .sel        (sel),
    .Penable    (bus.Penable),
    .stable     (stable),
    .state      (state),
    .setup_done (setup_done),
    .access_ok  (access_ok),
    .err        (fsm_err)
  );

  // Decode from the capture; on a clean access it equals the live address.
  assign idx       = cap_q.addr[WIN_BITS-1:2];
  assign in_window = (cap_q.addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]) &&
                     (cap_q.addr[1:0] == 2'b00);

  assign wr_hit    = access_ok && in_window && cap_q.write && (idx < REG_CNT);
  assign cnt_clr   = access_ok && in_window && cap_q.write && (idx == REG_CNT);
  assign rd_load   = access_ok && !cap_q.write;
  // A decode error on an otherwise clean access is one error event; an
  // unstable access is already flagged by the FSM, so the two never double up.
  assign err_event = fsm_err || (access_ok && !in_window);

  always_comb begin
    rd_data = '0;
    if (in_window) begin
      if (idx == REG_ID)       rd_data = ID_VALUE;
      else if (idx == REG_CNT) rd_data = {err_cnt, wr_cnt};
      else                     rd_data = regs[idx];
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      cap_q     <= '0;
      wr_cnt    <= '0;
      err_cnt   <= '0;
      pr_data_q <= '0;
      perr_q    <= 1'b0;
      // NOTE: the register array is built from flops rather than a RAM macro, so reset can clear it.
      for (int i = 0; i < int'(NUM_RW_REGS); i++) regs[i] <= '0;
    end else begin
      if (setup_done) cap_q <= '{addr: bus.Paddr, write: bus.Pwrite, wdata: bus.Pwdata};

      if (wr_hit) regs[idx] <= cap_q.wdata;

      // A clear through register 14 takes priority over any increment.
      if (cnt_clr) begin
        wr_cnt  <= '0;
        err_cnt <= '0;
      end else begin
        if (wr_hit)    wr_cnt  <= sat_inc16(wr_cnt);
        if (err_event) err_cnt <= sat_inc16(err_cnt);
      end

      // Read data holds between read loads; writes leave it untouched.
      if (rd_load) pr_data_q <= rd_data;

      perr_q <= err_event;
    end
  end

  assign bus.Pr_data = pr_data_q;
  assign bus.Perr    = perr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_regfile
// Self-checking bench for apb_slave_regfile: a table of fixed transfers with
// hand-derived results, directed multi-cycle corner sequences, and random
// transfers scored against a behavioural register-file model.
// ---------------------------------------------------------------------------
module tb_apb_slave_regfile;
  import apb_pkg::*;

  localparam int unsigned SLOT  = 1;
  localparam logic [2:0]  SEL   = 3'b010;
  localparam logic [2:0]  OTHER = 3'b101;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] ID    = 32'hA5B0_0001;

  logic Hclk = 1'b0;
  logic Hreset;

  apb_slave_regfile_if bus();

  apb_slave_regfile #(
    .SLOT      (SLOT),
    .BASE_ADDR (BASE),
    .ID_VALUE  (ID)
  ) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus)
  );

  always #5 Hclk = ~Hclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_state(input string name);
    check(name, 32'(dut.state), 32'(IDLE));
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [14];
  logic [15:0] m_wr, m_err;
  logic [31:0] m_rd;

  function automatic void model_reset();
    for (int i = 0; i < 14; i++) m_regs[i] = '0;
    m_wr  = '0;
    m_err = '0;
    m_rd  = '0;
  endfunction

  // Applies one well-formed transfer; returns 1 when it must raise Perr.
  function automatic logic model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic        ok;
    int unsigned n;
    ok = (addr >= BASE) && (addr < BASE + 32'd64) && (addr % 4 == 0);
    if (!ok) begin
      if (m_err != 16'hFFFF) m_err = m_err + 1;
      if (!wr) m_rd = '0;
      return 1'b1;
    end
    n = (addr - BASE) / 4;
    if (wr) begin
      if (n < 14) begin
        m_regs[n] = data;
        if (m_wr != 16'hFFFF) m_wr = m_wr + 1;
      end else if (n == 14) begin
        m_wr  = '0;
        m_err = '0;
      end
    end else begin
      if (n == 15)      m_rd = ID;
      else if (n == 14) m_rd = {m_err, m_wr};
      else              m_rd = m_regs[n];
    end
    return 1'b0;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic idle();
    bus.Psel    = 3'b000;
    bus.Penable = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    bus.Psel    = 3'b000;
    bus.Penable = 1'b0;
    Hreset      = 1'b1;
    tick();
    tick();
    Hreset = 1'b0;
    model_reset();
  endtask

  // Setup + access; returns in the cycle after the access edge, where
  // Pr_data and Perr reflect this transfer. Leaves Psel up so the caller
  // either chains another transfer or calls idle().
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output logic perr);
    bus.Psel    = SEL;
    bus.Penable = 1'b0;
    bus.Pwrite  = wr;
    bus.Paddr   = addr;
    bus.Pwdata  = data;
    tick();
    bus.Penable = 1'b1;
    tick();
    rd          = bus.Pr_data;
    perr        = bus.Perr;
    bus.Penable = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        pe;
    xfer(1'b0, addr, 32'h0, rd, pe);
    check({name, " data"}, rd, exp);
    idle();
  endtask

  task automatic write_nochk(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        pe;
    xfer(1'b1, addr, data, rd, pe);
    check("plain write perr", {31'b0, pe}, 32'd0);
    idle();
  endtask

  // ---------------- fixed vectors ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_perr;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    logic [31:0] rd;
    logic        pe, exp_pe;
    logic [31:0] addr, data;
    logic        wr;

    bus.Pwrite  = 1'b0;
    bus.Paddr   = '0;
    bus.Pwdata  = '0;
    do_reset();
    check("reset Pr_data", bus.Pr_data, 32'h0);
    check("reset Perr", {31'b0, bus.Perr}, 32'h0);
    check_idle_state("reset state");

    // Back-to-back table; expected Pr_data for writes is the held read value.
    vecs.push_back('{wr:1, addr:32'h8000_0008, data:32'hDEAD_BEEF, exp_rd:32'h0000_0000, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_0008, data:32'h0,         exp_rd:32'hDEAD_BEEF, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_0038, data:32'h0,         exp_rd:32'h0000_0001, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_003C, data:32'h0,         exp_rd:32'hA5B0_0001, exp_perr:0});
    vecs.push_back('{wr:1, addr:32'h8000_003C, data:32'h0,         exp_rd:32'hA5B0_0001, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_003C, data:32'h0,         exp_rd:32'hA5B0_0001, exp_perr:0});
    vecs.push_back('{wr:1, addr:32'h8000_0042, data:32'h0000_1234, exp_rd:32'hA5B0_0001, exp_perr:1});
    vecs.push_back('{wr:1, addr:32'h9000_0000, data:32'h0000_5555, exp_rd:32'hA5B0_0001, exp_perr:1});
    vecs.push_back('{wr:0, addr:32'h8000_0042, data:32'h0,         exp_rd:32'h0000_0000, exp_perr:1});
    vecs.push_back('{wr:0, addr:32'h9000_0000, data:32'h0,         exp_rd:32'h0000_0000, exp_perr:1});
    vecs.push_back('{wr:0, addr:32'h8000_0038, data:32'h0,         exp_rd:32'h0004_0001, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_0000, data:32'h0,         exp_rd:32'h0000_0000, exp_perr:0});
    vecs.push_back('{wr:1, addr:32'h8000_0038, data:32'hFFFF_FFFF, exp_rd:32'h0000_0000, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_0038, data:32'h0,         exp_rd:32'h0000_0000, exp_perr:0});
    vecs.push_back('{wr:1, addr:32'h8000_0034, data:32'hCAFE_F00D, exp_rd:32'h0000_0000, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_0034, data:32'h0,         exp_rd:32'hCAFE_F00D, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_0038, data:32'h0,         exp_rd:32'h0000_0001, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_0008, data:32'h0,         exp_rd:32'hDEAD_BEEF, exp_perr:0});
    vecs.push_back('{wr:0, addr:32'h8000_0040, data:32'h0,         exp_rd:32'h0000_0000, exp_perr:1});
    vecs.push_back('{wr:0, addr:32'h8000_0038, data:32'h0,         exp_rd:32'h0001_0001, exp_perr:0});

    foreach (vecs[i]) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, pe);
      check($sformatf("vec%0d Pr_data", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d Perr", i), {31'b0, pe}, {31'b0, vecs[i].exp_perr});
    end
    idle();
    check("table Perr drops", {31'b0, bus.Perr}, 32'h0);

    // Penable high on the first selected cycle.
    do_reset();
    bus.Psel = SEL; bus.Penable = 1'b1; bus.Paddr = BASE; bus.Pwrite = 1'b1;
    tick();
    check("early enable Perr", {31'b0, bus.Perr}, 32'h1);
    check_idle_state("early enable state");
    idle();
    check("early enable pulse width", {31'b0, bus.Perr}, 32'h0);
    read_expect("early enable cnt", 32'h8000_0038, 32'h0001_0000);

    // Address changed between setup and access: write dropped.
    do_reset();
    bus.Psel = SEL; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_0004; bus.Pwdata = 32'h0000_1111;
    tick();
    bus.Penable = 1'b1; bus.Paddr = 32'h8000_0008;
    tick();
    check("addr change Perr", {31'b0, bus.Perr}, 32'h1);
    idle();
    check("addr change pulse width", {31'b0, bus.Perr}, 32'h0);
    write_nochk(32'h8000_0038, 32'h0);
    read_expect("addr change cnt", 32'h8000_0038, 32'h0);
    read_expect("addr change old", 32'h8000_0004, 32'h0);
    read_expect("addr change new", 32'h8000_0008, 32'h0);

    // Write data changed between setup and access.
    bus.Psel = SEL; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_0010; bus.Pwdata = 32'h0000_AAAA;
    tick();
    bus.Penable = 1'b1; bus.Pwdata = 32'h0000_BBBB;
    tick();
    check("data change Perr", {31'b0, bus.Perr}, 32'h1);
    idle();
    read_expect("data change reg", 32'h8000_0010, 32'h0);

    // Reset during the access phase of a write.
    do_reset();
    xfer(1'b0, 32'h8000_003C, 32'h0, rd, pe);
    check("pre-reset id", rd, ID);
    bus.Psel = SEL; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_0010; bus.Pwdata = 32'h0000_0077;
    tick();
    bus.Penable = 1'b1; Hreset = 1'b1;
    tick();
    check("mid reset Pr_data", bus.Pr_data, 32'h0);
    check("mid reset Perr", {31'b0, bus.Perr}, 32'h0);
    check_idle_state("mid reset state");
    Hreset = 1'b0;
    idle();
    read_expect("mid reset reg", 32'h8000_0010, 32'h0);
    read_expect("mid reset cnt", 32'h8000_0038, 32'h0);

    // Penable held into the next cycle, setup abandoned, repeated setup,
    // and traffic for other slots.
    do_reset();
    xfer(1'b1, 32'h8000_0000, 32'h0000_0011, rd, pe);
    bus.Penable = 1'b1;
    tick();
    check("held enable Perr", {31'b0, bus.Perr}, 32'h1);
    check_idle_state("held enable state");
    idle();
    check("held enable pulse width", {31'b0, bus.Perr}, 32'h0);

    bus.Psel = SEL; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_0004; bus.Pwdata = 32'h0000_0022;
    tick();
    bus.Psel = 3'b000;
    tick();
    check("abandoned setup Perr", {31'b0, bus.Perr}, 32'h1);
    check_idle_state("abandoned setup state");
    idle();

    bus.Psel = SEL; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_0004; bus.Pwdata = 32'h0000_0033;
    tick();
    bus.Paddr = 32'h8000_0008; bus.Pwdata = 32'h0000_0044;
    tick();
    bus.Penable = 1'b1;
    tick();
    check("repeated setup Perr", {31'b0, bus.Perr}, 32'h0);
    idle();

    bus.Psel = OTHER; bus.Penable = 1'b1; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_000C; bus.Pwdata = 32'h0000_0055;
    tick();
    bus.Penable = 1'b0;
    tick();
    bus.Penable = 1'b1;
    tick();
    check("other slot Perr", {31'b0, bus.Perr}, 32'h0);
    check_idle_state("other slot state");
    idle();

    read_expect("held enable reg", 32'h8000_0000, 32'h0000_0011);
    read_expect("abandoned reg", 32'h8000_0004, 32'h0);
    read_expect("repeated setup reg", 32'h8000_0008, 32'h0000_0044);
    read_expect("other slot reg", 32'h8000_000C, 32'h0);
    read_expect("corner cnt", 32'h8000_0038, 32'h0002_0002);

    // Random well-formed transfers against the model.
    do_reset();
    for (int t = 0; t < 400; t++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      wr   = 1'($urandom_range(0, 1));
      data = $urandom();
      if (kind == 0) begin
        addr = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      end else if (kind == 1) begin
        addr = $urandom();
        if (addr[31:6] == BASE[31:6]) addr = addr ^ 32'h1000_0000;
      end else begin
        addr = BASE + 32'($urandom_range(0, 15) * 4);
      end
      exp_pe = model_xfer(wr, addr, data);
      xfer(wr, addr, data, rd, pe);
      check($sformatf("rand%0d Pr_data", t), rd, m_rd);
      check($sformatf("rand%0d Perr", t), {31'b0, pe}, {31'b0, exp_pe});
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    for (int r = 0; r < 16; r++) begin
      addr   = BASE + 32'(r * 4);
      exp_pe = model_xfer(1'b0, addr, 32'h0);
      xfer(1'b0, addr, 32'h0, rd, pe);
      check($sformatf("final reg%0d", r), rd, m_rd);
      idle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB-side register-file slave that sits directly downstream of the AHB-to-APB bridge. It consumes one bit of the bridge's one-hot `Psel` together with `Penable`, `Pwrite`, `Paddr` and `Pwdata`, and returns `Pr_data` to the bridge. It holds 16 word registers: 14 general read/write, one counter/status register, one read-only ID. It also checks the APB setup/access sequence and flags protocol errors.

## Interface
- `SLOT`, 0: index of the `Psel` bit this slave answers to (0..2).
- `BASE_ADDR`, 32'h8000_0000: window base; the window is 64 bytes.
- `ID_VALUE`, 32'hA5B0_0001: constant read from register 15.
- `Hclk`  in  1  single clock; all state updates on its rising edge.
- `Hreset`  in  1  synchronous, active-high reset.
- `Pwrite`  in  1  1 = write, 0 = read.
- `Psel`  in  3  one-hot slave select from the bridge.
- `Penable`  in  1  APB access-phase strobe.
- `Paddr`  in  32  byte address.
- `Pwdata`  in  32  write data.
- `Pr_data`  out  32  read data to the bridge.
- `Perr`  out  1  one-cycle pulse on a protocol or decode error.

## Operation
- `sel` is `Psel[SLOT]`.
- Register index is `Paddr[5:2]`.
- An address is in-window when `Paddr[31:6] == BASE_ADDR[31:6]` and `Paddr[1:0] == 0`; anything else is a decode error.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP when `sel` and not `Penable`.
  - IDLE with `sel` and `Penable` → protocol error; stay in IDLE.
  - SETUP → ACCESS when `sel` and `Penable`.
  - SETUP with `sel` and not `Penable` → stay in SETUP; the capture is re-taken.
  - SETUP with not `sel` → error; go to IDLE.
  - ACCESS → SETUP when `sel` and not `Penable` (back-to-back transfer).
  - ACCESS → IDLE when not `sel`.
  - ACCESS with `sel` and `Penable` still high → error (no wait states exist); go to IDLE.
- SETUP capture: `Paddr`, `Pwrite` and `Pwdata` are captured on the edge leaving SETUP.
  - If any of them differs from the captured value during ACCESS, that is a protocol error and the write is dropped.
- Write: committed on the edge ending a clean ACCESS cycle.
  - Registers 0–13 take `Pwdata`.
  - A write to register 14 clears both of its counters.
  - A write to register 15 is ignored and is not an error.
- Read: `Pr_data` is loaded on the SETUP→ACCESS edge and holds until the next read load.
  - Decode error → 0.
  - Register 15 → `ID_VALUE`.
  - Register 14 → {err_cnt[15:0], wr_cnt[15:0]}.
- Counters:
  - `wr_cnt` increments on each committed write to registers 0–13.
  - `err_cnt` increments on each error.
  - Both saturate at 16'hFFFF.
  - A clear through register 14 wins over an increment in the same cycle.
- `Perr`: registered; high for exactly the one cycle after an error edge; one pulse per error event.

## Timing
- Reset (synchronous, `Hreset` = 1 at an edge):
  - FSM goes to IDLE.
  - All 16 storage registers, both counters, captures, `Pr_data` and `Perr` go to 0.
- Reset mid-transfer aborts the transfer; no write commits on that edge.
- Read latency: data is valid for the whole ACCESS cycle of the same transfer, one edge after SETUP.
- Write latency: the new value is readable by the next transfer; a read-after-write in back-to-back transfers returns the new value.
- A transfer is exactly 2 cycles. Minimum back-to-back rate is one transfer per 2 cycles.
- `sel` bits for other slots are ignored entirely; multiple `Psel` bits high is the bridge's fault and is not checked.

## Structure
- Shared package `apb_pkg` holds:
  - the FSM state enum (IDLE/SETUP/ACCESS);
  - the register-index constants `REG_CNT` = 14 and `REG_ID` = 15;
  - the window width constant (6).
- One sub-module, `apb_protocol_fsm`: takes `sel`/`Penable` and the stability compare, and produces the state, `setup_done`, `access_ok` and `err`.
- The register array, counters and read mux stay in the top.

## Test plan
- Write 32'hDEAD_BEEF to 0x8000_0008, then read 0x8000_0008 → `Pr_data` = 32'hDEAD_BEEF in the ACCESS cycle; register 14 reads 32'h0000_0001.
- Read 0x8000_003C → 32'hA5B0_0001. Write 0 to 0x8000_003C → no `Perr`; a re-read still returns the ID.
- `Penable` high on the first `sel` cycle → `Perr` pulses for 1 cycle; FSM stays in IDLE; reading register 14 afterwards → err_cnt = 1.
- Write to 0x8000_0042 (misaligned) and to 0x9000_0000 → `Perr` for each; no register changes; reads of the same addresses return 0.
- `Paddr` changed between SETUP and ACCESS on a write → write dropped, `Perr` pulses. Then write to 0x8000_0038 → register 14 reads 0.
- Assert `Hreset` during the ACCESS cycle of a write → the target register stays 0; `Pr_data`, `Perr` and the FSM are all 0/IDLE on the next cycle.
